// File: rtl/imem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
//   owner_e  : which requester issued a memory access
//   tag_t    : per-access return tag {valid, owner}
package imem_arbiter_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned MAX_LATENCY = 2;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified memory port.
//   slave  : arbiter view (requests and memory read data in, grants/returns/memory strobes out)
//   master : environment view (fetch stage, load/store unit and memory)
interface imem_arbiter_if;
  import imem_arbiter_pkg::*;

  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              fetch_enable_o;
  logic [DATA_W-1:0] fetch_rdata_o;
  logic              fetch_rvalid_o;

  logic              data_req_i;
  logic [BE_W-1:0]   data_we_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_rvalid_o;

  logic              mem_en_o;
  logic [BE_W-1:0]   mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
    input  mem_rdata_i,
    output fetch_enable_o, fetch_rdata_o, fetch_rvalid_o,
    output data_gnt_o, data_rdata_o, data_rvalid_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    output data_req_i, data_we_i, data_addr_i, data_wdata_i,
    output mem_rdata_i,
    input  fetch_enable_o, fetch_rdata_o, fetch_rvalid_o,
    input  data_gnt_o, data_rdata_o, data_rvalid_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/imem_arbiter_tag_pipe.sv
// arb_tag_pipe: DEPTH-stage shift register of access tags; tag_o is the stage
// aligned with the memory read data.
//   clk, reset_n : clock, async active-low reset
//   clr_i        : sync clear of every stage (drops in-flight tags)
//   tag_i        : tag of the access issued this cycle
//   tag_o        : tag of the access whose data returns this cycle
module arb_tag_pipe
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port synchronous memory between instruction
// fetch and the load/store port. Data wins by default; fetch_enable_o stalls
// fetch when it loses. Read data is routed back by a tag pipeline matching
// MEM_LATENCY.
//   clk, reset_n : clock, async active-low reset
//   sys_reset    : sync reset, same effect as reset_n
//   bus          : fetch, load/store and memory signals (imem_arbiter_if.slave)
// Optional: define IMEM_ARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_MAX consecutive fetch losses.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sys_reset,
  imem_arbiter_if.slave  bus
);

  localparam int unsigned TAG_DEPTH = (MEM_LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                                      (MEM_LATENCY < 1)           ? 1 : MEM_LATENCY;

  logic              active_c;
  logic              force_fetch_c;
  logic              data_gnt_c;
  logic              fetch_gnt_c;
  tag_t              tag_in_c;
  tag_t              tag_out_c;
  logic              fetch_rv_c;
  logic              data_rv_c;
  logic [DATA_W-1:0] fetch_last_q;
  logic [DATA_W-1:0] data_last_q;

  // Either reset silences every output, including the combinational grants.
  assign active_c = reset_n & ~sys_reset;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  // Count fetch losses; saturate at STARVE_MAX, clear once fetch is served or idle.
  always_comb begin
    force_fetch_c = bus.fetch_req_i && (starve_q >= CNT_W'(STARVE_MAX));
    starve_d      = starve_q;
    if (!bus.fetch_req_i || fetch_gnt_c) begin
      starve_d = '0;
    end else if (data_gnt_c && (starve_q < CNT_W'(STARVE_MAX))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       starve_q <= '0;
    else if (sys_reset) starve_q <= '0;
    else                starve_q <= starve_d;
  end
`else
  // Strict data priority; STARVE_MAX only matters with the guard built in.
  assign force_fetch_c = 1'b0 && (STARVE_MAX != 0);
`endif

  assign data_gnt_c  = active_c && bus.data_req_i && !force_fetch_c;
  assign fetch_gnt_c = active_c && bus.fetch_req_i && !data_gnt_c;

  assign bus.data_gnt_o     = data_gnt_c;
  assign bus.fetch_enable_o = fetch_gnt_c;

  // Memory port follows the grant; writes only from the data side.
  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (data_gnt_c) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = bus.data_we_i;
      bus.mem_addr_o  = bus.data_addr_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end else if (fetch_gnt_c) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_addr_o = bus.fetch_addr_i;
    end
  end

  // Writes return nothing, so they travel as invalid tags.
  always_comb begin
    tag_in_c.valid = fetch_gnt_c || (data_gnt_c && (bus.data_we_i == '0));
    tag_in_c.owner = data_gnt_c ? OWN_DATA : OWN_FETCH;
  end

  arb_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (sys_reset),
    .tag_i   (tag_in_c),
    .tag_o   (tag_out_c)
  );

  assign fetch_rv_c = active_c && tag_out_c.valid && (tag_out_c.owner == OWN_FETCH);
  assign data_rv_c  = active_c && tag_out_c.valid && (tag_out_c.owner == OWN_DATA);

  // Last returned word per port, so rdata holds between returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_last_q <= '0;
      data_last_q  <= '0;
    end else if (sys_reset) begin
      fetch_last_q <= '0;
      data_last_q  <= '0;
    end else begin
      if (fetch_rv_c) fetch_last_q <= bus.mem_rdata_i;
      if (data_rv_c)  data_last_q  <= bus.mem_rdata_i;
    end
  end

  assign bus.fetch_rvalid_o = fetch_rv_c;
  assign bus.data_rvalid_o  = data_rv_c;
  assign bus.fetch_rdata_o  = !active_c ? '0 : (fetch_rv_c ? bus.mem_rdata_i : fetch_last_q);
  assign bus.data_rdata_o   = !active_c ? '0 : (data_rv_c  ? bus.mem_rdata_i : data_last_q);

endmodule
